// File: rtl/fu_result_buffer_pkg.sv
// rtl/fu_result_buffer_pkg.sv - shared widths, FU lane indices and result entry type
package fu_result_buffer_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    localparam int FU_ALU  = 0;
    localparam int FU_MULT = 1;
    localparam int FU_LSU  = 2;
    localparam int FU_BTU  = 3;

    typedef struct packed {
        logic [XLEN-1:0]        value;
        logic [ROB_TAG_LEN-1:0] tag;
        logic                   mis_predict;
        logic [XLEN-1:0]        target_pc;
    } fu_result_entry_t;
endpackage

// File: rtl/fu_result_fifo.sv
// rtl/fu_result_fifo.sv - single-lane result FIFO with zeroed head when empty
module fu_result_fifo
    import fu_result_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fu_result_entry_t push_data,
    input  logic             pop,
    output fu_result_entry_t head_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fu_result_entry_t mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while the lane is empty.
    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fu_result_buffer.sv
// rtl/fu_result_buffer.sv - per-FU result FIFOs between the functional units and the CDB arbiter
module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NUM_FU-1:0]                     fu_valid,
    input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
    input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_tag,
    input  logic                                  fu_mis_predict_in,
    input  logic [XLEN-1:0]                       fu_target_pc_in,
    output logic [NUM_FU-1:0]                     fu_ready,
    input  logic [1:0]                            cdb_select_fu,
    input  logic                                  cdb_enable,
    output logic [NUM_FU-1:0][XLEN-1:0]           fu_results,
    output logic [NUM_FU-1:0]                     fu_result_ready,
    output logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_tags,
    output logic                                  fu_mis_predict,
    output logic [XLEN-1:0]                       fu_target_pc
);
    fu_result_entry_t        push_data [NUM_FU];
    fu_result_entry_t        head      [NUM_FU];
    logic [NUM_FU-1:0]       empty;
    logic [NUM_FU-1:0]       full;
    logic                    unused_extras;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
        logic pop;

        assign push_data[i].value = fu_value[i];
        assign push_data[i].tag   = fu_tag[i];
        if (i == FU_BTU) begin : g_btu
            assign push_data[i].mis_predict = fu_mis_predict_in;
            assign push_data[i].target_pc   = fu_target_pc_in;
        end else begin : g_plain
            assign push_data[i].mis_predict = 1'b0;
            assign push_data[i].target_pc   = '0;
        end

        assign pop = cdb_enable && (cdb_select_fu == 2'(i));

        fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .push      (fu_valid[i]),
            .push_data (push_data[i]),
            .pop       (pop),
            .head_data (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );

        // Ready comes from registered fullness only, so a grant never reaches back to the FU.
        assign fu_ready[i]        = !full[i];
        assign fu_result_ready[i] = !empty[i];
        assign fu_results[i]      = head[i].value;
        assign fu_tags[i]         = head[i].tag;
    end

    assign fu_mis_predict = head[FU_BTU].mis_predict;
    assign fu_target_pc   = head[FU_BTU].target_pc;

    always_comb begin
        unused_extras = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (i != FU_BTU) unused_extras = unused_extras ^ head[i].mis_predict ^ (^head[i].target_pc);
        end
    end
endmodule

// File: tb/tb_fu_result_buffer.sv
// tb/tb_fu_result_buffer.sv - table-driven and directed checks for fu_result_buffer
module tb_fu_result_buffer;
    import fu_result_buffer_pkg::*;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          flush;
    logic [3:0]                    fu_valid;
    logic [3:0][XLEN-1:0]          fu_value;
    logic [3:0][ROB_TAG_LEN-1:0]   fu_tag;
    logic                          fu_mis_predict_in;
    logic [XLEN-1:0]               fu_target_pc_in;
    logic [3:0]                    fu_ready;
    logic [1:0]                    cdb_select_fu;
    logic                          cdb_enable;
    logic [3:0][XLEN-1:0]          fu_results;
    logic [3:0]                    fu_result_ready;
    logic [3:0][ROB_TAG_LEN-1:0]   fu_tags;
    logic                          fu_mis_predict;
    logic [XLEN-1:0]               fu_target_pc;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fu_result_buffer #(.NUM_FU(4), .DEPTH(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .fu_valid          (fu_valid),
        .fu_value          (fu_value),
        .fu_tag            (fu_tag),
        .fu_mis_predict_in (fu_mis_predict_in),
        .fu_target_pc_in   (fu_target_pc_in),
        .fu_ready          (fu_ready),
        .cdb_select_fu     (cdb_select_fu),
        .cdb_enable        (cdb_enable),
        .fu_results        (fu_results),
        .fu_result_ready   (fu_result_ready),
        .fu_tags           (fu_tags),
        .fu_mis_predict    (fu_mis_predict),
        .fu_target_pc      (fu_target_pc)
    );

    typedef struct {
        logic        flush;
        logic [3:0]  valid;
        logic [4:0]  tag;
        logic        mis;
        logic [31:0] pc;
        logic        en;
        logic [1:0]  sel;
        logic [3:0]  exp_rr;
        logic [3:0]  exp_rdy;
        logic [3:0][4:0] exp_tags;
        logic        exp_mis;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vec [15];

    function automatic logic [31:0] val_of(input logic [4:0] t, input int lane);
        return 32'hC0DE_0000 + 32'(lane << 8) + 32'(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; fu_valid = '0; fu_value = '0; fu_tag = '0;
        fu_mis_predict_in = 1'b0; fu_target_pc_in = '0;
        cdb_enable = 1'b0; cdb_select_fu = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //              flush valid    tag  mis pc          en sel   rr       rdy      tags lane3..lane0                   mis pc
        vec[0]  = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0000, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 32'h0};
        vec[1]  = '{1'b0, 4'b0001, 5'd1, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0, 32'h0};
        vec[2]  = '{1'b0, 4'b0001, 5'd2, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0001, 4'b1110, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0, 32'h0};
        vec[3]  = '{1'b0, 4'b0001, 5'd3, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0001, 4'b1110, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0, 32'h0};
        vec[4]  = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b1, 2'd0, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd2}, 1'b0, 32'h0};
        vec[5]  = '{1'b0, 4'b0001, 5'd3, 1'b0, 32'h0,   1'b1, 2'd0, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd3}, 1'b0, 32'h0};
        vec[6]  = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b1, 2'd0, 4'b0000, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 32'h0};
        vec[7]  = '{1'b0, 4'b1000, 5'd6, 1'b1, 32'h100, 1'b0, 2'd0, 4'b1000, 4'b1111, {5'd6, 5'd0, 5'd0, 5'd0}, 1'b1, 32'h100};
        vec[8]  = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b0, 2'd0, 4'b1000, 4'b1111, {5'd6, 5'd0, 5'd0, 5'd0}, 1'b1, 32'h100};
        vec[9]  = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b1, 2'd3, 4'b0000, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 32'h0};
        vec[10] = '{1'b0, 4'b1111, 5'd9, 1'b0, 32'h0,   1'b0, 2'd0, 4'b1111, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, 1'b0, 32'h0};
        vec[11] = '{1'b1, 4'b0010, 5'd7, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0000, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 32'h0};
        vec[12] = '{1'b0, 4'b0001, 5'd4, 1'b0, 32'h0,   1'b0, 2'd0, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd4}, 1'b0, 32'h0};
        vec[13] = '{1'b0, 4'b0000, 5'd0, 1'b0, 32'h0,   1'b1, 2'd3, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd4}, 1'b0, 32'h0};
        vec[14] = '{1'b0, 4'b0001, 5'd5, 1'b0, 32'h0,   1'b1, 2'd0, 4'b0001, 4'b1111, {5'd0, 5'd0, 5'd0, 5'd5}, 1'b0, 32'h0};

        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int s = 0; s < 15; s++) begin
            flush = vec[s].flush;
            fu_valid = vec[s].valid;
            for (int l = 0; l < 4; l++) begin
                fu_value[l] = val_of(vec[s].tag, l);
                fu_tag[l]   = vec[s].tag;
            end
            fu_mis_predict_in = vec[s].mis;
            fu_target_pc_in   = vec[s].pc;
            cdb_enable        = vec[s].en;
            cdb_select_fu     = vec[s].sel;
            tick();
            idle();
            chk($sformatf("step%0d result_ready", s), 32'(fu_result_ready), 32'(vec[s].exp_rr));
            chk($sformatf("step%0d fu_ready", s), 32'(fu_ready), 32'(vec[s].exp_rdy));
            chk($sformatf("step%0d mis_predict", s), 32'(fu_mis_predict), 32'(vec[s].exp_mis));
            chk($sformatf("step%0d target_pc", s), fu_target_pc, vec[s].exp_pc);
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("step%0d tag[%0d]", s, l), 32'(fu_tags[l]), 32'(vec[s].exp_tags[l]));
                chk($sformatf("step%0d value[%0d]", s, l), fu_results[l],
                    vec[s].exp_rr[l] ? val_of(vec[s].exp_tags[l], l) : 32'h0);
            end
        end

        // Lane 0 holds tag 5 here; push lane 2 and confirm there is no same-cycle bypass.
        fu_valid = 4'b0100; fu_value[2] = 32'hDEAD_BEEF; fu_tag[2] = 5'd5;
        #1;
        chk("no_bypass result_ready", 32'(fu_result_ready), 32'h1);
        tick();
        idle();
        chk("lane2 result_ready", 32'(fu_result_ready), 32'h5);
        chk("lane2 tag", 32'(fu_tags[2]), 32'd5);
        chk("lane2 value", fu_results[2], 32'hDEAD_BEEF);
        cdb_enable = 1'b1; cdb_select_fu = 2'd2;
        tick();
        idle();
        chk("lane2 popped ready", 32'(fu_result_ready), 32'h1);
        chk("lane2 popped value", fu_results[2], 32'h0);

        // A full lane being popped still reports not-ready in that cycle.
        fu_valid = 4'b0001; fu_value[0] = val_of(5'd6, 0); fu_tag[0] = 5'd6;
        tick();
        idle();
        chk("full fu_ready", 32'(fu_ready), 32'hE);
        cdb_enable = 1'b1; cdb_select_fu = 2'd0;
        #1;
        chk("full popping fu_ready", 32'(fu_ready), 32'hE);
        tick();
        idle();
        chk("after pop fu_ready", 32'(fu_ready), 32'hF);
        chk("after pop tag0", 32'(fu_tags[0]), 32'd6);

        // Reset mid-operation with a concurrent push.
        fu_valid = 4'b0010; fu_value[1] = val_of(5'd2, 1); fu_tag[1] = 5'd2;
        tick();
        reset = 1'b1;
        fu_valid = 4'b0100; fu_value[2] = val_of(5'd3, 2); fu_tag[2] = 5'd3;
        tick();
        idle();
        reset = 1'b0;
        chk("reset result_ready", 32'(fu_result_ready), 32'h0);
        chk("reset fu_ready", 32'(fu_ready), 32'hF);
        chk("reset tags", 32'(fu_tags), 32'h0);
        chk("reset value0", fu_results[0], 32'h0);
        chk("reset value1", fu_results[1], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fu_result_buffer.md
Name: fu_result_buffer

Overview:
- Holding stage between the four functional units (FUs) and the common data bus (CDB) arbiter.
- Each FU lane has a small FIFO that captures completed results (value, ROB tag and, on the BTU lane, mispredict flag and target PC).
- The head of each lane is presented to the CDB; a lane is popped only when the CDB picks it.
- Back-pressure to each FU is given by a per-lane ready signal; a global flush discards all buffered results.

Parameters:
- NUM_FU, 4: number of FU lanes. Fixed to match the CDB's 2-bit select.
- DEPTH, 2: entries per lane FIFO. Must be at least 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered entries.
- fu_valid  in  [NUM_FU]  FU i presents a result this cycle.
- fu_value  in  [NUM_FU][XLEN]  result value per FU.
- fu_tag  in  [NUM_FU][ROB_TAG_LEN]  destination ROB tag per FU.
- fu_mis_predict_in  in  1  BTU mispredict flag; sampled only with fu_valid[FU_BTU].
- fu_target_pc_in  in  XLEN  BTU resolved target PC; sampled only with fu_valid[FU_BTU].
- fu_ready  out  [NUM_FU]  lane i can accept a push this cycle.
- cdb_select_fu  in  2  CDB select_fu output.
- cdb_enable  in  1  CDB rob_enable output; a grant is taken this cycle.
- fu_results  out  [NUM_FU][XLEN]  head value per lane, to the CDB.
- fu_result_ready  out  [NUM_FU]  lane i is non-empty.
- fu_tags  out  [NUM_FU][ROB_TAG_LEN]  head tag per lane.
- fu_mis_predict  out  1  mispredict flag of the BTU lane head.
- fu_target_pc  out  XLEN  target PC of the BTU lane head.

Behaviour:
- Clock, reset and flush:
  - One clock domain; all state updates on the rising edge of clock.
  - Reset is synchronous and active-high. It clears all pointers and counts to 0.
  - After reset: fu_result_ready=0, fu_results=0, fu_tags=0, fu_mis_predict=0, fu_target_pc=0, fu_ready all 1.
  - Reset asserted mid-operation discards every entry, with no partial state kept.
- Lane state: rd_ptr, wr_ptr, count, with count width $clog2(DEPTH+1).
  - Pointers advance modulo DEPTH: DEPTH-1 wraps to 0.
- Push: when fu_valid[i] && fu_ready[i], the entry is written at wr_ptr and wr_ptr increments.
  - fu_valid[i] while fu_ready[i]=0 is dropped. The FU must hold its result; the buffer does not latch it.
- fu_ready[i] = (count[i] != DEPTH).
  - It depends on registered state only, so there is no combinational path from the CDB grant to the FU.
  - A full lane that pops this cycle still reports not-ready.
- Pop: lane i pops when cdb_enable && cdb_select_fu==i && count[i]!=0.
  - A grant on an empty lane is ignored, with no pointer change.
  - Exactly one lane pops per cycle at most.
- Simultaneous push and pop on one lane: count is unchanged, both pointers advance, and the head becomes the next older entry.
- Head outputs:
  - Combinational from the registered array at rd_ptr.
  - Outputs are zero when the lane is empty.
  - fu_result_ready[i] = (count[i]!=0).
- Latency:
  - A result pushed in cycle N is visible on fu_result_ready in cycle N+1. There is no write-through bypass.
  - A lane popped in cycle N shows its next entry, or empty, in cycle N+1.
- BTU extras: fu_mis_predict and fu_target_pc are stored only in lane FU_BTU and track that lane's head.
- Flush:
  - Flush has priority over push and pop in the same cycle.
  - All counts and pointers go to 0, and any push in the flush cycle is discarded.
  - Outputs are empty in cycle N+1 and fu_ready is all 1.
- Ordering:
  - Within a lane, strict FIFO order.
  - Across lanes there are no ordering guarantees; CDB priority (lane 0 highest) decides.
  - Starvation of higher-index lanes is acceptable.

Decomposition:
- XLEN, ROB_TAG_LEN and the FU index constants (FU_ALU, FU_MULT, FU_LSU, FU_BTU) live in sys_defs.svh.
- Add to the same package a typedef fu_result_entry_t {value, tag, mis_predict, target_pc}.
- Natural sub-module: fu_result_fifo, a single-lane parameterised FIFO.
  - Ports: clock, reset, flush, push, push_data, pop, head_data, empty, full.
  - Instantiate NUM_FU times; only the BTU instance carries the extra fields, the others tie them to 0.

Test Plan:
- Reset, then idle:
  - Response: fu_result_ready=4'b0000, fu_ready=4'b1111, all data outputs 0.
- Single push and grant:
  - Stimulus: push lane 2 (value 32'hDEAD_BEEF, tag 5).
  - Next cycle: fu_result_ready=4'b0100, fu_tags[2]=5.
  - Then drive cdb_select_fu=2, cdb_enable=1.
  - Following cycle: lane 2 is empty.
- Fill and wrap with DEPTH=2:
  - Stimulus: push lane 0 with tags 1 then 2.
  - Response: fu_ready[0]=0. A third push (tag 3) while full is dropped.
  - Pop once: next cycle head tag=2 and fu_ready[0]=1.
  - Push tag 3 and pop together: head becomes 3 with count 1, confirming pointer wrap.
- BTU payload:
  - Stimulus: push lane FU_BTU with mis_predict=1, target_pc=32'h0000_0100.
  - Response: fu_mis_predict=1 and fu_target_pc=32'h100 until popped, then 0.
- Flush with simultaneous push:
  - Stimulus: all lanes hold one entry; assert flush while also pushing lane 1 (tag 7).
  - Next cycle: fu_result_ready=4'b0000 and tag 7 is absent.
- Grant on empty lane:
  - Stimulus: cdb_select_fu=3, cdb_enable=1 with lane 3 empty and lane 0 holding tag 4.
  - Response: no state change; lane 0 still shows tag 4.
